// File: rtl/bp_fe_fetch_buffer_if.sv
// Handshake bundle between the FE fetch stage (enqueue side), the BE queue
// output (dequeue side) and the fetch buffer itself.
interface bp_fe_fetch_buffer_if #(
    parameter int entry_width_p = 64,
    parameter int els_p         = 8,
    parameter int enq_width_p   = 2
);
    localparam int count_width_lp = $clog2(els_p + 1);

    logic                                   flush_i;
    logic [enq_width_p-1:0]                 enq_v_i;
    logic [enq_width_p*entry_width_p-1:0]   enq_data_i;
    logic                                   enq_ready_o;
    logic [entry_width_p-1:0]               deq_data_o;
    logic                                   deq_v_o;
    logic                                   deq_yumi_i;
    logic [count_width_lp-1:0]              count_o;
    logic                                   overflow_o;

    // The fetch/BE environment drives the requests and sees the status.
    modport master (
        output flush_i, enq_v_i, enq_data_i, deq_yumi_i,
        input  enq_ready_o, deq_data_o, deq_v_o, count_o, overflow_o
    );

    modport slave (
        input  flush_i, enq_v_i, enq_data_i, deq_yumi_i,
        output enq_ready_o, deq_data_o, deq_v_o, count_o, overflow_o
    );
endinterface

// File: rtl/bp_fe_fetch_buffer.sv
// Multi-lane FE fetch buffer: up to enq_width_p entries in per cycle, one out,
// single-cycle flush on redirect, occupancy and sticky overflow reporting.
module bp_fe_fetch_buffer #(
    parameter int entry_width_p = 64,
    parameter int els_p         = 8,
    parameter int enq_width_p   = 2
) (
    input  logic                clk_i,
    input  logic                reset_i,
    bp_fe_fetch_buffer_if.slave bus
);
    localparam int ptr_width_lp   = (els_p == 1) ? 1 : $clog2(els_p);
    localparam int count_width_lp = $clog2(els_p + 1);
    localparam int n_width_lp     = $clog2(enq_width_p + 1);

    logic [entry_width_p-1:0]  mem [els_p];
    logic [ptr_width_lp-1:0]   rptr_reg, wptr_reg;
    logic [count_width_lp-1:0] count_reg;
    logic                      overflow_reg;

    logic [ptr_width_lp-1:0]   rptr_next, wptr_next;
    logic [count_width_lp-1:0] count_next;
    logic [n_width_lp-1:0]     enq_n;
    logic                      enq_req, enq_ready, enq_fire, deq_fire, overflow_set;
    logic [ptr_width_lp-1:0]   lane_addr [enq_width_p];

    // Increments never exceed els_p, so one conditional subtract wraps correctly.
    function automatic logic [ptr_width_lp-1:0] wrap_add(
        input logic [ptr_width_lp-1:0] base,
        input logic [ptr_width_lp:0]   inc
    );
        logic [ptr_width_lp:0] sum;
        sum = {1'b0, base} + inc;
        if (sum >= (ptr_width_lp+1)'(els_p))
            sum = sum - (ptr_width_lp+1)'(els_p);
        return sum[ptr_width_lp-1:0];
    endfunction

    for (genvar gi = 0; gi < enq_width_p; gi++) begin : g_lane
        assign lane_addr[gi] = wrap_add(wptr_reg, (ptr_width_lp+1)'(gi));
    end

    always_comb begin
        enq_n = '0;
        for (int i = 0; i < enq_width_p; i++)
            enq_n = enq_n + n_width_lp'(bus.enq_v_i[i]);
    end

    // Readiness ignores a same-cycle dequeue so yumi never reaches enq_ready_o.
    assign enq_ready    = (count_reg <= count_width_lp'(els_p - enq_width_p));
    assign enq_req      = |bus.enq_v_i;
    assign enq_fire     = enq_req & enq_ready & ~bus.flush_i;
    assign deq_fire     = bus.deq_yumi_i & (count_reg != '0) & ~bus.flush_i;
    assign overflow_set = enq_req & ~enq_ready & ~bus.flush_i;

    assign wptr_next  = wrap_add(wptr_reg, (ptr_width_lp+1)'(enq_n));
    assign rptr_next  = wrap_add(rptr_reg, (ptr_width_lp+1)'(1));
    assign count_next = count_reg
                      + (enq_fire ? count_width_lp'(enq_n) : '0)
                      - count_width_lp'(deq_fire);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rptr_reg     <= '0;
            wptr_reg     <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (overflow_set)
                overflow_reg <= 1'b1;
            if (bus.flush_i) begin
                rptr_reg  <= '0;
                wptr_reg  <= '0;
                count_reg <= '0;
            end else begin
                if (enq_fire)
                    wptr_reg <= wptr_next;
                if (deq_fire)
                    rptr_reg <= rptr_next;
                count_reg <= count_next;
            end
        end
    end

    // Storage carries no reset; only lanes covered by enq_v_i are written.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < enq_width_p; i++) begin
            if (enq_fire && bus.enq_v_i[i])
                mem[lane_addr[i]] <= bus.enq_data_i[i*entry_width_p +: entry_width_p];
        end
    end

    assign bus.enq_ready_o = enq_ready;
    assign bus.deq_v_o     = (count_reg != '0);
    assign bus.deq_data_o  = mem[rptr_reg];
    assign bus.count_o     = count_reg;
    assign bus.overflow_o  = overflow_reg;

`ifndef SYNTHESIS
    // Lanes must be filled from lane 0 upward, and yumi only offered on valid.
    a_enq_thermometer: assert property (@(posedge clk_i) disable iff (reset_i)
        ((bus.enq_v_i & (bus.enq_v_i + 1'b1)) == '0));
    a_yumi_on_valid: assert property (@(posedge clk_i) disable iff (reset_i)
        !(bus.deq_yumi_i && !bus.deq_v_o));
`endif
endmodule

// File: tb/tb_bp_fe_fetch_buffer.sv
// Scoreboarded bench: stimulus pushes expected head entries, negedge monitors
// pop and compare on every consumed entry; status outputs checked directly.
module tb_bp_fe_fetch_buffer;
    localparam int EW = 16;

    logic clk;
    logic reset_i;
    int   n_vec  = 0;
    int   n_miss = 0;

    logic [EW-1:0] q8[$];
    logic [EW-1:0] q6[$];

    bp_fe_fetch_buffer_if #(.entry_width_p(EW), .els_p(8), .enq_width_p(2)) if8 ();
    bp_fe_fetch_buffer_if #(.entry_width_p(EW), .els_p(6), .enq_width_p(2)) if6 ();

    bp_fe_fetch_buffer #(.entry_width_p(EW), .els_p(8), .enq_width_p(2)) dut8 (
        .clk_i(clk), .reset_i(reset_i), .bus(if8)
    );
    bp_fe_fetch_buffer #(.entry_width_p(EW), .els_p(6), .enq_width_p(2)) dut6 (
        .clk_i(clk), .reset_i(reset_i), .bus(if6)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitors: a consumed head must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset_i && !if8.flush_i && if8.deq_yumi_i) begin
            n_vec++;
            if (q8.size() == 0) begin
                n_miss++;
                $display("FAIL deq8: got %0h, expected nothing (scoreboard empty)", if8.deq_data_o);
            end else begin
                logic [EW-1:0] e;
                e = q8.pop_front();
                if (!if8.deq_v_o || if8.deq_data_o !== e) begin
                    n_miss++;
                    $display("FAIL deq8: got v=%0b data=%0h, expected v=1 data=%0h",
                             if8.deq_v_o, if8.deq_data_o, e);
                end else
                    $display("deq8 %0h ok", e);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset_i && !if6.flush_i && if6.deq_yumi_i) begin
            n_vec++;
            if (q6.size() == 0) begin
                n_miss++;
                $display("FAIL deq6: got %0h, expected nothing (scoreboard empty)", if6.deq_data_o);
            end else begin
                logic [EW-1:0] e;
                e = q6.pop_front();
                if (!if6.deq_v_o || if6.deq_data_o !== e) begin
                    n_miss++;
                    $display("FAIL deq6: got v=%0b data=%0h, expected v=1 data=%0h",
                             if6.deq_v_o, if6.deq_data_o, e);
                end else
                    $display("deq6 %0h ok", e);
            end
        end
    end

    // Present one bundle on the 8-deep buffer; accepted lanes go to the scoreboard.
    task automatic enq8(input logic [1:0] v, input logic [EW-1:0] d1, input logic [EW-1:0] d0,
                        input logic yumi, input logic expect_accept);
        if8.enq_v_i    = v;
        if8.enq_data_i = {d1, d0};
        if8.deq_yumi_i = yumi;
        if (expect_accept) begin
            if (v[0]) q8.push_back(d0);
            if (v[1]) q8.push_back(d1);
        end
        step();
        if8.enq_v_i    = 2'b00;
        if8.deq_yumi_i = 1'b0;
    endtask

    initial begin
        reset_i        = 1'b1;
        if8.flush_i    = 1'b0; if8.enq_v_i = '0; if8.enq_data_i = '0; if8.deq_yumi_i = 1'b0;
        if6.flush_i    = 1'b0; if6.enq_v_i = '0; if6.enq_data_i = '0; if6.deq_yumi_i = 1'b0;
        repeat (2) step();
        chk("reset_count",    32'(if8.count_o),     0);
        chk("reset_deq_v",    32'(if8.deq_v_o),     0);
        chk("reset_ready",    32'(if8.enq_ready_o), 1);
        chk("reset_overflow", 32'(if8.overflow_o),  0);
        reset_i = 1'b0;
        step();

        // Fill with three bundles, then a fourth to reach full.
        enq8(2'b11, 16'hA001, 16'hA000, 1'b0, 1'b1);
        chk("fill_count_a", 32'(if8.count_o), 2);
        enq8(2'b11, 16'hB001, 16'hB000, 1'b0, 1'b1);
        chk("fill_count_b", 32'(if8.count_o), 4);
        enq8(2'b11, 16'hC001, 16'hC000, 1'b0, 1'b1);
        chk("fill_count_c", 32'(if8.count_o), 6);
        chk("fill_ready_c", 32'(if8.enq_ready_o), 1);
        enq8(2'b11, 16'hD001, 16'hD000, 1'b0, 1'b1);
        chk("full_count", 32'(if8.count_o), 8);
        chk("full_ready", 32'(if8.enq_ready_o), 0);
        chk("full_deq_v", 32'(if8.deq_v_o), 1);

        if8.deq_yumi_i = 1'b1;
        repeat (8) step();
        if8.deq_yumi_i = 1'b0;
        chk("drain_count", 32'(if8.count_o), 0);
        chk("drain_deq_v", 32'(if8.deq_v_o), 0);

        // Partial bundle: only lane 0 is valid, lane 1 data must never appear.
        enq8(2'b01, 16'hE1E1, 16'hE0E0, 1'b0, 1'b1);
        chk("partial_count", 32'(if8.count_o), 1);
        chk("partial_head",  32'(if8.deq_data_o), 32'h0000E0E0);
        if8.deq_yumi_i = 1'b1;
        step();
        if8.deq_yumi_i = 1'b0;
        chk("partial_drain", 32'(if8.count_o), 0);

        // Simultaneous enqueue/dequeue near full, then a rejected enqueue.
        enq8(2'b11, 16'h1001, 16'h1000, 1'b0, 1'b1);
        enq8(2'b11, 16'h2001, 16'h2000, 1'b0, 1'b1);
        enq8(2'b11, 16'h3001, 16'h3000, 1'b0, 1'b1);
        chk("sim_count6", 32'(if8.count_o), 6);
        enq8(2'b11, 16'h4001, 16'h4000, 1'b1, 1'b1);
        chk("sim_count7", 32'(if8.count_o), 7);
        chk("sim_ready7", 32'(if8.enq_ready_o), 0);
        chk("sim_ovf_pre", 32'(if8.overflow_o), 0);
        enq8(2'b01, 16'h0000, 16'h5000, 1'b0, 1'b0);
        chk("ovf_set",    32'(if8.overflow_o), 1);
        chk("ovf_count7", 32'(if8.count_o), 7);
        enq8(2'b01, 16'h0000, 16'h5000, 1'b1, 1'b0);
        chk("ovf_yumi_count", 32'(if8.count_o), 6);

        // Flush beats a same-cycle enqueue and yumi.
        if8.deq_yumi_i = 1'b1;
        step();
        if8.deq_yumi_i = 1'b0;
        chk("pre_flush_count", 32'(if8.count_o), 5);
        if8.flush_i = 1'b1;
        q8.delete();
        enq8(2'b11, 16'h6001, 16'h6000, 1'b1, 1'b0);
        if8.flush_i = 1'b0;
        chk("flush_count",    32'(if8.count_o), 0);
        chk("flush_deq_v",    32'(if8.deq_v_o), 0);
        chk("flush_keeps_ovf", 32'(if8.overflow_o), 1);
        enq8(2'b01, 16'h0000, 16'h7777, 1'b0, 1'b1);
        chk("post_flush_v",    32'(if8.deq_v_o), 1);
        chk("post_flush_head", 32'(if8.deq_data_o), 32'h00007777);
        if8.deq_yumi_i = 1'b1;
        step();
        if8.deq_yumi_i = 1'b0;

        // Reset asserted mid-cycle must act before the next clock edge.
        enq8(2'b11, 16'h8001, 16'h8000, 1'b0, 1'b1);
        chk("prereset_count", 32'(if8.count_o), 2);
        #2;
        reset_i = 1'b1;
        #1;
        chk("async_reset_count", 32'(if8.count_o),     0);
        chk("async_reset_deq_v", 32'(if8.deq_v_o),     0);
        chk("async_reset_ready", 32'(if8.enq_ready_o), 1);
        chk("async_reset_ovf",   32'(if8.overflow_o),  0);
        q8.delete();
        step();
        step();
        #2;
        reset_i = 1'b0;
        step();

        // Wrap on the 6-deep buffer: one in, one out per cycle.
        if6.enq_v_i    = 2'b01;
        if6.enq_data_i = {16'h0000, 16'hC000};
        q6.push_back(16'hC000);
        step();
        for (int k = 1; k <= 20; k++) begin
            if6.enq_data_i = {16'h0000, 16'(16'hC000 + k)};
            if6.deq_yumi_i = 1'b1;
            q6.push_back(16'(16'hC000 + k));
            step();
            chk($sformatf("wrap_count_%0d", k), 32'(if6.count_o), 1);
        end
        if6.enq_v_i    = 2'b00;
        step();
        if6.deq_yumi_i = 1'b0;
        chk("wrap_drain_count", 32'(if6.count_o), 0);

        chk("scoreboard8_empty", 32'(q8.size()), 0);
        chk("scoreboard6_empty", 32'(q6.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
